// File: rtl/mvs_panel_rx_pkg.sv
// Shared types and constants for the MVS panel receiver: seven-segment codes,
// the BCD-to-segment decode and the EL deserialiser state encoding.
package mvs_panel_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    EL_IDLE  = 1'b0,
    EL_SHIFT = 1'b1
  } el_state_e;

  // Segment order is {g,f,e,d,c,b,a}; non-decimal nibbles show blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mvs_panel_rx_if.sv
// Front-panel bundle between the MVS board outputs and the cabinet receiver.
// master = board/panel driver side, slave = mvs_panel_rx.
interface mvs_panel_if #(
  parameter int EL_BITS = 8
);
  logic [8:0]           LED_OUT1;
  logic [8:0]           LED_OUT2;
  logic [3:0]           EL_OUT;
  logic [7:0]           LED1_DIGITS;
  logic [7:0]           LED2_DIGITS;
  logic                 LED1_VALID;
  logic                 LED2_VALID;
  logic [6:0]           LED1_SEG_HI;
  logic [6:0]           LED1_SEG_LO;
  logic [6:0]           LED2_SEG_HI;
  logic [6:0]           LED2_SEG_LO;
  logic                 LED1_STB;
  logic                 LED2_STB;
  logic [3*EL_BITS-1:0] EL_DATA;
  logic                 EL_STB;
  logic                 EL_ERR;

  modport master (
    output LED_OUT1, LED_OUT2, EL_OUT,
    input  LED1_DIGITS, LED2_DIGITS, LED1_VALID, LED2_VALID,
           LED1_SEG_HI, LED1_SEG_LO, LED2_SEG_HI, LED2_SEG_LO,
           LED1_STB, LED2_STB, EL_DATA, EL_STB, EL_ERR
  );

  modport slave (
    input  LED_OUT1, LED_OUT2, EL_OUT,
    output LED1_DIGITS, LED2_DIGITS, LED1_VALID, LED2_VALID,
           LED1_SEG_HI, LED1_SEG_LO, LED2_SEG_HI, LED2_SEG_LO,
           LED1_STB, LED2_STB, EL_DATA, EL_STB, EL_ERR
  );

endinterface

// File: rtl/mvs_panel_rx_sync.sv
// 2-FF synchroniser plus registered copy; sync_o and rise_o are aligned and
// appear two edges after the input is first sampled. No backpressure.
module panel_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] rise_q, rise_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  // prev_q is the value the edge was detected on, so data and pulse line up.
  assign sync_o = prev_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/mvs_panel_rx.sv
// MVS front-panel receiver: credit-LED latch/decode and EL serial deframer.
// LED latch 3 edges after strobe sampling, EL commit EL_TIMEOUT after last edge; no backpressure.
module mvs_panel_rx
  import mvs_panel_pkg::*;
#(
  parameter int EL_BITS    = 8,
  parameter int EL_TIMEOUT = 256
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  mvs_panel_if.slave  pnl
);

  localparam int BCW = $clog2(EL_BITS + 2);
  localparam int IDW = $clog2(EL_TIMEOUT + 1);

  logic [8:0] led1_sync, led1_rise;
  logic [8:0] led2_sync, led2_rise;
  logic [3:0] el_sync, el_rise;

  panel_sync #(.W(9)) u_sync_led1 (
    .clk(CLK_24M), .rst_n(nRESET), .din(pnl.LED_OUT1),
    .sync_o(led1_sync), .rise_o(led1_rise)
  );
  panel_sync #(.W(9)) u_sync_led2 (
    .clk(CLK_24M), .rst_n(nRESET), .din(pnl.LED_OUT2),
    .sync_o(led2_sync), .rise_o(led2_rise)
  );
  panel_sync #(.W(4)) u_sync_el (
    .clk(CLK_24M), .rst_n(nRESET), .din(pnl.EL_OUT),
    .sync_o(el_sync), .rise_o(el_rise)
  );

  logic unused_rise;
  assign unused_rise = ^{led1_rise[7:0], led2_rise[7:0], el_rise[2:0], el_sync[3]};

  logic [7:0] led1_digits_q, led1_digits_d;
  logic [7:0] led2_digits_q, led2_digits_d;
  logic       led1_valid_q, led1_valid_d;
  logic       led2_valid_q, led2_valid_d;
  logic       led1_stb_q, led1_stb_d;
  logic       led2_stb_q, led2_stb_d;

  always_comb begin
    led1_digits_d = led1_digits_q;
    led1_valid_d  = led1_valid_q;
    led1_stb_d    = 1'b0;
    led2_digits_d = led2_digits_q;
    led2_valid_d  = led2_valid_q;
    led2_stb_d    = 1'b0;
    if (led1_rise[8]) begin
      led1_digits_d = led1_sync[7:0];
      led1_valid_d  = 1'b1;
      led1_stb_d    = 1'b1;
    end
    if (led2_rise[8]) begin
      led2_digits_d = led2_sync[7:0];
      led2_valid_d  = 1'b1;
      led2_stb_d    = 1'b1;
    end
  end

  el_state_e                  state_q, state_d;
  logic [2:0][EL_BITS-1:0]    shreg_q, shreg_d, shreg_shift;
  logic [BCW-1:0]             bitcnt_q, bitcnt_d;
  logic [IDW-1:0]             idle_q, idle_d;
  logic [3*EL_BITS-1:0]       el_data_q, el_data_d;
  logic                       el_stb_q, el_stb_d;
  logic                       el_err_q, el_err_d;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      shreg_shift[k] = {shreg_q[k][EL_BITS-2:0], el_sync[k]};
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    idle_d    = idle_q;
    el_data_d = el_data_q;
    el_stb_d  = 1'b0;
    el_err_d  = 1'b0;
    case (state_q)
      EL_IDLE: begin
        if (el_rise[3]) begin
          shreg_d  = shreg_shift;
          bitcnt_d = BCW'(1);
          idle_d   = '0;
          state_d  = EL_SHIFT;
        end
      end
      EL_SHIFT: begin
        if (el_rise[3]) begin
          // An edge always wins over a timeout landing in the same cycle.
          shreg_d = shreg_shift;
          if (bitcnt_q != BCW'(EL_BITS + 1)) begin
            bitcnt_d = bitcnt_q + BCW'(1);
          end
          idle_d = '0;
        end else if (idle_q == IDW'(EL_TIMEOUT - 1)) begin
          if (bitcnt_q == BCW'(EL_BITS)) begin
            el_data_d = shreg_q;
            el_stb_d  = 1'b1;
          end else begin
            el_err_d  = 1'b1;
          end
          bitcnt_d = '0;
          idle_d   = '0;
          state_d  = EL_IDLE;
        end else if (idle_q != IDW'(EL_TIMEOUT)) begin
          idle_d = idle_q + IDW'(1);
        end
      end
      default: state_d = EL_IDLE;
    endcase
  end

  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      led1_digits_q <= '0;
      led2_digits_q <= '0;
      led1_valid_q  <= 1'b0;
      led2_valid_q  <= 1'b0;
      led1_stb_q    <= 1'b0;
      led2_stb_q    <= 1'b0;
      state_q       <= EL_IDLE;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      idle_q        <= '0;
      el_data_q     <= '0;
      el_stb_q      <= 1'b0;
      el_err_q      <= 1'b0;
    end else begin
      led1_digits_q <= led1_digits_d;
      led2_digits_q <= led2_digits_d;
      led1_valid_q  <= led1_valid_d;
      led2_valid_q  <= led2_valid_d;
      led1_stb_q    <= led1_stb_d;
      led2_stb_q    <= led2_stb_d;
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bitcnt_q      <= bitcnt_d;
      idle_q        <= idle_d;
      el_data_q     <= el_data_d;
      el_stb_q      <= el_stb_d;
      el_err_q      <= el_err_d;
    end
  end

  assign pnl.LED1_DIGITS = led1_digits_q;
  assign pnl.LED2_DIGITS = led2_digits_q;
  assign pnl.LED1_VALID  = led1_valid_q;
  assign pnl.LED2_VALID  = led2_valid_q;
  assign pnl.LED1_STB    = led1_stb_q;
  assign pnl.LED2_STB    = led2_stb_q;
  assign pnl.LED1_SEG_HI = led1_valid_q ? bcd_to_seg(led1_digits_q[7:4]) : SEG_BLANK;
  assign pnl.LED1_SEG_LO = led1_valid_q ? bcd_to_seg(led1_digits_q[3:0]) : SEG_BLANK;
  assign pnl.LED2_SEG_HI = led2_valid_q ? bcd_to_seg(led2_digits_q[7:4]) : SEG_BLANK;
  assign pnl.LED2_SEG_LO = led2_valid_q ? bcd_to_seg(led2_digits_q[3:0]) : SEG_BLANK;
  assign pnl.EL_DATA     = el_data_q;
  assign pnl.EL_STB      = el_stb_q;
  assign pnl.EL_ERR      = el_err_q;

endmodule

// File: tb/tb_mvs_panel_rx.sv
// Directed bench for mvs_panel_rx with a strobe-driven scoreboard.
module tb_mvs_panel_rx;

  localparam int ELB  = 8;
  localparam int ELT  = 256;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mvs_panel_if #(.EL_BITS(ELB)) pnl ();

  mvs_panel_rx #(.EL_BITS(ELB), .EL_TIMEOUT(ELT)) dut (
    .CLK_24M(clk),
    .nRESET (nrst),
    .pnl    (pnl)
  );

  typedef struct {
    int         cyc;
    logic [7:0] dig;
    logic [6:0] hi;
    logic [6:0] lo;
  } led_exp_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [23:0] data;
  } el_exp_t;

  led_exp_t led1_q[$];
  led_exp_t led2_q[$];
  el_exp_t  el_q[$];
  led_exp_t e1, e2;
  el_exp_t  ee;
  int n_led1 = 0, n_led2 = 0, n_el_stb = 0, n_el_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every strobe pops the oldest expectation for its display/stream.
  always @(negedge clk) begin
    if (pnl.LED1_STB) begin
      n_led1++;
      chk("led1_stb_expected", 32'(led1_q.size() != 0), 1);
      if (led1_q.size() != 0) begin
        e1 = led1_q.pop_front();
        chk("led1_latency", cyc, e1.cyc);
        chk("led1_digits", pnl.LED1_DIGITS, e1.dig);
        chk("led1_valid", pnl.LED1_VALID, 1);
        chk("led1_seg_hi", pnl.LED1_SEG_HI, e1.hi);
        chk("led1_seg_lo", pnl.LED1_SEG_LO, e1.lo);
      end
    end
    if (pnl.LED2_STB) begin
      n_led2++;
      chk("led2_stb_expected", 32'(led2_q.size() != 0), 1);
      if (led2_q.size() != 0) begin
        e2 = led2_q.pop_front();
        chk("led2_latency", cyc, e2.cyc);
        chk("led2_digits", pnl.LED2_DIGITS, e2.dig);
        chk("led2_valid", pnl.LED2_VALID, 1);
        chk("led2_seg_hi", pnl.LED2_SEG_HI, e2.hi);
        chk("led2_seg_lo", pnl.LED2_SEG_LO, e2.lo);
      end
    end
    if (pnl.EL_STB) n_el_stb++;
    if (pnl.EL_ERR) n_el_err++;
    if (pnl.EL_STB || pnl.EL_ERR) begin
      chk("el_event_expected", 32'(el_q.size() != 0), 1);
      if (el_q.size() != 0) begin
        ee = el_q.pop_front();
        chk("el_latency", cyc, ee.cyc);
        chk("el_err", pnl.EL_ERR, ee.err);
        chk("el_stb", pnl.EL_STB, !ee.err);
        chk("el_data", pnl.EL_DATA, ee.data);
      end
    end
  end

  // One serial frame, MSB first; stretch >= 0 delays that bit's clock edge
  // until exactly ELT cycles after the previous edge.
  task automatic el_frame(input int n, input logic [15:0] l0, input logic [15:0] l1,
                          input logic [15:0] l2, input int stretch, output int last_c);
    last_c = 0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      pnl.EL_OUT = {1'b0, l2[i], l1[i], l0[i]};
      repeat (3) @(negedge clk);
      if (i == stretch) begin
        while (cyc < last_c + ELT) @(negedge clk);
      end
      pnl.EL_OUT[3] = 1'b1;
      last_c = cyc;
      repeat (3) @(negedge clk);
      pnl.EL_OUT[3] = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (el_q.size() + led1_q.size() + led2_q.size()) != 0; i++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    chk(tag, el_q.size() + led1_q.size() + led2_q.size(), 0);
  endtask

  int lc;
  logic [23:0] el_model;

  initial begin
    pnl.LED_OUT1 = '0;
    pnl.LED_OUT2 = '0;
    pnl.EL_OUT   = '0;
    el_model     = '0;
    repeat (5) @(negedge clk);
    nrst = 1'b1;
    repeat (50) @(negedge clk);

    chk("rst_led1_digits", pnl.LED1_DIGITS, 0);
    chk("rst_led2_digits", pnl.LED2_DIGITS, 0);
    chk("rst_led1_valid", pnl.LED1_VALID, 0);
    chk("rst_led2_valid", pnl.LED2_VALID, 0);
    chk("rst_segs", {pnl.LED1_SEG_HI, pnl.LED1_SEG_LO, pnl.LED2_SEG_HI, pnl.LED2_SEG_LO}, 0);
    chk("rst_el_data", pnl.EL_DATA, 0);
    chk("rst_strobes", {pnl.LED1_STB, pnl.LED2_STB, pnl.EL_STB, pnl.EL_ERR}, 0);

    // LED1 = 25
    pnl.LED_OUT1 = 9'h025;
    repeat (3) @(negedge clk);
    pnl.LED_OUT1[8] = 1'b1;
    led1_q.push_back('{cyc + 4, 8'h25, 7'h5B, 7'h6D});
    repeat (6) @(negedge clk);
    pnl.LED_OUT1[8] = 1'b0;
    drain("led1_drain", 20);
    chk("led2_untouched_valid", pnl.LED2_VALID, 0);
    chk("led2_untouched_segs", {pnl.LED2_SEG_HI, pnl.LED2_SEG_LO}, 0);
    chk("led1_hold_seg_hi", pnl.LED1_SEG_HI, 7'h5B);

    // Simultaneous strobes: 19 and 3A (low nibble blank)
    pnl.LED_OUT1 = 9'h019;
    pnl.LED_OUT2 = 9'h03A;
    repeat (3) @(negedge clk);
    pnl.LED_OUT1[8] = 1'b1;
    pnl.LED_OUT2[8] = 1'b1;
    led1_q.push_back('{cyc + 4, 8'h19, 7'h06, 7'h6F});
    led2_q.push_back('{cyc + 4, 8'h3A, 7'h4F, 7'h00});
    repeat (6) @(negedge clk);
    pnl.LED_OUT1[8] = 1'b0;
    pnl.LED_OUT2[8] = 1'b0;
    drain("led_pair_drain", 20);

    // Good frame A5/FF/01
    el_frame(8, 16'h00A5, 16'h00FF, 16'h0001, -1, lc);
    el_model = 24'h01FFA5;
    el_q.push_back('{lc + 4 + ELT, 1'b0, el_model});
    drain("el_good_drain", ELT + 50);

    // Short frame then long frame
    el_frame(5, 16'h001B, 16'h0004, 16'h0011, -1, lc);
    el_q.push_back('{lc + 4 + ELT, 1'b1, el_model});
    drain("el_short_drain", ELT + 50);
    el_frame(9, 16'h01AB, 16'h0155, 16'h00F0, -1, lc);
    el_q.push_back('{lc + 4 + ELT, 1'b1, el_model});
    drain("el_long_drain", ELT + 50);
    chk("el_data_retained", pnl.EL_DATA, 24'h01FFA5);

    // Edge landing on the timeout cycle continues the frame
    el_frame(8, 16'h00C3, 16'h0096, 16'h007E, 3, lc);
    el_model = 24'h7E96C3;
    el_q.push_back('{lc + 4 + ELT, 1'b0, el_model});
    drain("el_stretch_drain", ELT + 50);

    // Reset mid-frame, then a fresh frame
    el_frame(4, 16'h000F, 16'h0000, 16'h000A, -1, lc);
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_el_data", pnl.EL_DATA, 0);
    chk("midrst_led1_valid", pnl.LED1_VALID, 0);
    chk("midrst_led1_seg", {pnl.LED1_SEG_HI, pnl.LED1_SEG_LO}, 0);
    el_frame(8, 16'h003C, 16'h005A, 16'h0081, -1, lc);
    el_model = 24'h815A3C;
    el_q.push_back('{lc + 4 + ELT, 1'b0, el_model});
    drain("el_after_rst_drain", ELT + 50);
    repeat (ELT + 20) @(negedge clk);

    chk("count_led1_stb", n_led1, 2);
    chk("count_led2_stb", n_led2, 1);
    chk("count_el_stb", n_el_stb, 3);
    chk("count_el_err", n_el_err, 2);
    chk("final_el_data", pnl.EL_DATA, 24'h815A3C);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
